// File: rtl/integer_core_serial.sv
// Multi-cycle integer core: digit-serial add/sub/bitwise/compare and 1-bit/cycle shifts.
// Operands are latched on an accepted Start; Rd/Flag update only on the Done edge.
module integer_core_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Rs1,
    input  logic [WIDTH-1:0] Rs2,
    input  logic [WIDTH-1:0] Immediate,
    input  logic             CtrlUseImm,
    input  logic [3:0]       CtrlALUOp,
    input  logic             CtrlFlagInv,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Rd,
    output logic             Flag
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int SW    = $clog2(WIDTH);
    localparam int CW    = SW + 1;

    typedef enum logic [1:0] {IDLE, RUN_ALU, RUN_SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next, res_reg, res_next, rd_reg, rd_next;
    logic [3:0]       op_reg, op_next;
    logic             inv_reg, inv_next, carry_reg, carry_next, zero_reg, zero_next;
    logic             flag_reg, flag_next, done_reg, done_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    logic [WIDTH-1:0] b_mux, a_adv, b_adv, res_acc, shifted;
    logic [DIGIT-1:0] a_dig, b_eff, logic_dig, digit_res;
    logic [DIGIT:0]   sum;
    logic             op_sub, start_sub, cmp, sum_zero, ovf;

    assign b_mux     = CtrlUseImm ? Immediate : Rs2;
    // Compare is computed as A-B, so it shares the subtract carry-in of 1.
    assign start_sub = (CtrlALUOp[3:2] == 2'b11) || (CtrlALUOp[3:2] == 2'b01 && !CtrlALUOp[0]);
    assign op_sub    = (op_reg[3:2] == 2'b11) || (op_reg[3:2] == 2'b01 && !op_reg[0]);

    assign a_dig    = a_reg[DIGIT-1:0];
    assign b_eff    = op_sub ? ~b_reg[DIGIT-1:0] : b_reg[DIGIT-1:0];
    assign sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_reg};
    assign sum_zero = (sum[DIGIT-1:0] == '0);
    assign ovf      = (a_dig[DIGIT-1] == b_eff[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);

    always_comb begin
        case (op_reg[1:0])
            2'b01:   logic_dig = a_dig ^ b_reg[DIGIT-1:0];
            2'b10:   logic_dig = a_dig | b_reg[DIGIT-1:0];
            2'b11:   logic_dig = a_dig & b_reg[DIGIT-1:0];
            default: logic_dig = '0;
        endcase
    end

    assign digit_res = (op_reg[3:2] == 2'b00) ? logic_dig : sum[DIGIT-1:0];

    // Operands drain LSB-first; results enter at the top so the word is aligned after STEPS digits.
    generate
        if (STEPS == 1) begin : g_single
            assign a_adv   = a_reg;
            assign b_adv   = b_reg;
            assign res_acc = digit_res;
        end else begin : g_multi
            assign a_adv   = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
            assign b_adv   = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
            assign res_acc = {digit_res, res_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        case (op_reg[1:0])
            2'b01:   shifted = {a_reg[WIDTH-2:0], 1'b0};
            2'b10:   shifted = {1'b0, a_reg[WIDTH-1:1]};
            2'b11:   shifted = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
            default: shifted = a_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        inv_next   = inv_reg;
        carry_next = carry_reg;
        zero_next  = zero_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        rd_next    = rd_reg;
        flag_next  = flag_reg;
        done_next  = 1'b0;
        cmp        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    a_next     = Rs1;
                    b_next     = b_mux;
                    op_next    = CtrlALUOp;
                    inv_next   = CtrlFlagInv;
                    carry_next = start_sub;
                    zero_next  = 1'b1;
                    res_next   = '0;
                    if (CtrlALUOp[3:2] == 2'b10) begin
                        state_next = RUN_SHIFT;
                        cnt_next   = {1'b0, b_mux[SW-1:0]};
                    end else begin
                        state_next = RUN_ALU;
                        cnt_next   = CW'(STEPS - 1);
                    end
                end
            end
            RUN_ALU: begin
                a_next     = a_adv;
                b_next     = b_adv;
                carry_next = sum[DIGIT];
                zero_next  = zero_reg & sum_zero;
                res_next   = res_acc;
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    if (op_reg[3:2] == 2'b11) begin
                        if (op_reg[0])
                            cmp = zero_reg & sum_zero;
                        else if (op_reg[1])
                            cmp = ~sum[DIGIT];
                        else
                            cmp = sum[DIGIT-1] ^ ovf;
                        flag_next = cmp ^ inv_reg;
                        rd_next   = {{(WIDTH-1){1'b0}}, cmp ^ inv_reg};
                    end else begin
                        flag_next = 1'b0;
                        rd_next   = res_acc;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RUN_SHIFT: begin
                if (op_reg[1:0] == 2'b00 || cnt_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rd_next    = a_reg;
                    flag_next  = 1'b0;
                end else if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rd_next    = shifted;
                    flag_next  = 1'b0;
                end else begin
                    a_next   = shifted;
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            inv_reg   <= 1'b0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            rd_reg    <= '0;
            flag_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            inv_reg   <= inv_next;
            carry_reg <= carry_next;
            zero_reg  <= zero_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            rd_reg    <= rd_next;
            flag_reg  <= flag_next;
            done_reg  <= done_next;
        end
    end

    assign Busy = (state_reg != IDLE);
    assign Done = done_reg;
    assign Rd   = rd_reg;
    assign Flag = flag_reg;
endmodule

// File: tb/tb_integer_core_serial.sv
// Directed bench for integer_core_serial: one DIGIT=8 core plus a DIGIT=32 core for single-step latency.
module tb_integer_core_serial;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Start1 = 1'b0;
    logic [31:0] Rs1 = '0, Rs2 = '0, Immediate = '0;
    logic        CtrlUseImm = 1'b0;
    logic [3:0]  CtrlALUOp = '0;
    logic        CtrlFlagInv = 1'b0;
    logic        Busy, Done, Flag, Busy1, Done1, Flag1;
    logic [31:0] Rd, Rd1;

    int n_asserts = 0;
    int n_fail = 0;
    int lat;
    int pulses;

    integer_core_serial #(.WIDTH(32), .DIGIT(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rs1(Rs1), .Rs2(Rs2), .Immediate(Immediate),
        .CtrlUseImm(CtrlUseImm), .CtrlALUOp(CtrlALUOp), .CtrlFlagInv(CtrlFlagInv),
        .Busy(Busy), .Done(Done), .Rd(Rd), .Flag(Flag)
    );

    integer_core_serial #(.WIDTH(32), .DIGIT(32)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start1), .Rs1(Rs1), .Rs2(Rs2), .Immediate(Immediate),
        .CtrlUseImm(CtrlUseImm), .CtrlALUOp(CtrlALUOp), .CtrlFlagInv(CtrlFlagInv),
        .Busy(Busy1), .Done(Done1), .Rd(Rd1), .Flag(Flag1)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issues one op on the DIGIT=8 core and waits (bounded) for Done; sampled 1ns after edges.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic use_imm, input logic [3:0] op,
                          input logic inv, output int cycles);
        Rs1 = a; Rs2 = b; Immediate = imm; CtrlUseImm = use_imm; CtrlALUOp = op; CtrlFlagInv = inv;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        cycles = 0;
        while (!Done && cycles < 100) begin
            @(posedge Clk); #1;
            cycles++;
        end
        check({tag, "_done_seen"}, {31'd0, Done}, 32'd1);
        $display("op %s: A=%08h B=%08h op=%b -> Rd=%08h Flag=%0d after %0d cycles", tag, a,
                 use_imm ? imm : b, op, Rd, Flag, cycles);
    endtask

    initial begin
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_rd",   Rd,            32'd0);
        check("rst_flag", {31'd0, Flag}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b0101, 1'b0, lat);
        check("add_wrap_lat", lat, 32'd4);
        check("add_wrap_rd", Rd, 32'h0);
        check("add_wrap_flag", {31'd0, Flag}, 32'd0);

        run_op("slt", 32'h80000000, 32'h1, 32'h0, 1'b0, 4'b1100, 1'b0, lat);
        check("slt_flag", {31'd0, Flag}, 32'd1);
        check("slt_rd", Rd, 32'd1);

        run_op("slt_inv", 32'h80000000, 32'h1, 32'h0, 1'b0, 4'b1100, 1'b1, lat);
        check("slt_inv_flag", {31'd0, Flag}, 32'd0);
        check("slt_inv_rd", Rd, 32'd0);

        run_op("sltu", 32'h80000000, 32'h1, 32'h0, 1'b0, 4'b1110, 1'b0, lat);
        check("sltu_flag", {31'd0, Flag}, 32'd0);

        run_op("eq", 32'h12345678, 32'h12345678, 32'h0, 1'b0, 4'b1101, 1'b0, lat);
        check("eq_flag", {31'd0, Flag}, 32'd1);
        run_op("eq_msb", 32'h92345678, 32'h12345678, 32'h0, 1'b0, 4'b1101, 1'b0, lat);
        check("eq_msb_flag", {31'd0, Flag}, 32'd0);
        run_op("eq_lsb", 32'h12345679, 32'h12345678, 32'h0, 1'b0, 4'b1101, 1'b0, lat);
        check("eq_lsb_flag", {31'd0, Flag}, 32'd0);

        run_op("sra", 32'hF0000000, 32'h24, 32'h0, 1'b0, 4'b1011, 1'b0, lat);
        check("sra_lat", lat, 32'd4);
        check("sra_rd", Rd, 32'hFF000000);

        run_op("sll0", 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 4'b1001, 1'b0, lat);
        check("sll0_lat", lat, 32'd1);
        check("sll0_rd", Rd, 32'hDEADBEEF);

        run_op("sll5", 32'h00000001, 32'h5, 32'h0, 1'b0, 4'b1001, 1'b0, lat);
        check("sll5_lat", lat, 32'd5);
        check("sll5_rd", Rd, 32'h00000020);

        run_op("srl3", 32'h80000001, 32'h3, 32'h0, 1'b0, 4'b1010, 1'b0, lat);
        check("srl3_rd", Rd, 32'h10000000);

        run_op("sub", 32'h5, 32'h7, 32'h0, 1'b0, 4'b0100, 1'b0, lat);
        check("sub_rd", Rd, 32'hFFFFFFFE);
        check("sub_flag", {31'd0, Flag}, 32'd0);

        run_op("and", 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 4'b0011, 1'b0, lat);
        check("and_rd", Rd, 32'h0F000F00);

        run_op("bw00", 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 4'b0000, 1'b1, lat);
        check("bw00_rd", Rd, 32'h0);
        check("bw00_flag", {31'd0, Flag}, 32'd0);

        run_op("xor_imm", 32'hAAAA5555, 32'h12345678, 32'hFFFFFFFF, 1'b1, 4'b0001, 1'b0, lat);
        check("xor_imm_rd", Rd, 32'h5555AAAA);

        // Start pulses while busy must be ignored, and Rd must hold until Done.
        Rs1 = 32'h1; Rs2 = 32'h2; CtrlUseImm = 1'b0; CtrlALUOp = 4'b0101; CtrlFlagInv = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Rs1 = 32'h100; Rs2 = 32'h100; CtrlALUOp = 4'b0011;
        @(posedge Clk); #1;
        check("busy_hold_rd", Rd, 32'h5555AAAA);
        check("busy_hold_busy", {31'd0, Busy}, 32'd1);
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = 2;
        while (!Done && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("busy_ign_lat", lat, 32'd4);
        check("busy_ign_rd", Rd, 32'h3);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (Done) pulses++;
        end
        check("busy_ign_extra_done", pulses, 32'd0);
        $display("op busy_ign: Rd=%08h extra_done=%0d", Rd, pulses);

        // Back-to-back: the second run_op raises Start while Done of the first is high.
        run_op("b2b_sub", 32'h10, 32'h3, 32'h0, 1'b0, 4'b0100, 1'b0, lat);
        check("b2b_sub_rd", Rd, 32'hD);
        check("b2b_in_done_cycle", {31'd0, Done}, 32'd1);
        run_op("b2b_or", 32'hF0F00000, 32'h0000F0F0, 32'h0, 1'b0, 4'b0010, 1'b0, lat);
        check("b2b_or_lat", lat, 32'd4);
        check("b2b_or_rd", Rd, 32'hF0F0F0F0);

        // Asynchronous reset in the middle of an ALU run.
        Rs1 = 32'h5; Rs2 = 32'h6; CtrlALUOp = 4'b0101;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_rd",   Rd,            32'd0);
        check("arst_flag", {31'd0, Flag}, 32'd0);
        $display("op arst: Busy=%0d Done=%0d Rd=%08h Flag=%0d", Busy, Done, Rd, Flag);
        @(posedge Clk); #1;
        Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            if (Done || Busy) pulses++;
        end
        check("arst_no_done", pulses, 32'd0);
        run_op("post_rst_add", 32'h5, 32'h6, 32'h0, 1'b0, 4'b0101, 1'b0, lat);
        check("post_rst_add_rd", Rd, 32'd11);

        // Single-step core (DIGIT = WIDTH).
        Rs1 = 32'hFFFFFFFF; Rs2 = 32'h1; CtrlUseImm = 1'b0; CtrlALUOp = 4'b0101; CtrlFlagInv = 1'b0;
        Start1 = 1'b1;
        @(posedge Clk); #1;
        Start1 = 1'b0;
        lat = 0;
        while (!Done1 && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("d32_lat", lat, 32'd1);
        check("d32_rd", Rd1, 32'h0);
        check("d32_flag", {31'd0, Flag1}, 32'd0);
        $display("op d32_add: Rd=%08h Flag=%0d after %0d cycles", Rd1, Flag1, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
